// File: rtl/mem_tester.sv
// Built-in memory tester: writes Seed^address to WordCount consecutive words,
// reads them back, counts mismatches and flags per-access timeouts.
module mem_tester #(
  parameter logic [31:0] BaseAddress   = 32'h0000_0000,
  parameter int          WordCount     = 16,
  parameter logic [31:0] Seed          = 32'h1234_5678,
  parameter int          TimeoutCycles = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [31:0] first_error_address,
  output logic        c_enable,
  output logic [3:0]  c_write_enable,
  output logic [31:0] c_address,
  output logic [31:0] c_data_in,
  input  logic [31:0] c_data_out,
  input  logic        c_data_out_ready,
  input  logic        c_busy
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE
  } state_t;

  localparam logic [15:0] LastIdx = 16'(WordCount - 1);
  localparam logic [31:0] TmoLast = 32'(TimeoutCycles - 1);

  state_t      state, state_nxt;
  logic [15:0] idx, idx_nxt;
  logic [31:0] tcnt, tcnt_nxt;
  logic        done_nxt, pass_nxt, timeout_nxt;
  logic [15:0] err_nxt;
  logic [31:0] first_nxt;
  logic        en_nxt;
  logic [3:0]  we_nxt;
  logic [31:0] addr_nxt, din_nxt;
  logic        acc_done;
  logic        mismatch;
  logic [15:0] err_upd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, request registers and result bookkeeping
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    tcnt_nxt    = tcnt;
    done_nxt    = done;
    pass_nxt    = pass;
    timeout_nxt = timeout;
    err_nxt     = error_count;
    first_nxt   = first_error_address;
    en_nxt      = c_enable;
    we_nxt      = c_write_enable;
    addr_nxt    = c_address;
    din_nxt     = c_data_in;
    acc_done    = 1'b0;
    mismatch    = 1'b0;
    err_upd     = error_count;

    case (state)
      IDLE, DONE: begin
        en_nxt = 1'b0;
        we_nxt = 4'b0000;
        if (start) begin
          idx_nxt     = '0;
          tcnt_nxt    = '0;
          err_nxt     = '0;
          first_nxt   = '0;
          done_nxt    = 1'b0;
          pass_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          en_nxt      = 1'b1;
          we_nxt      = 4'b1111;
          addr_nxt    = BaseAddress;
          din_nxt     = Seed ^ BaseAddress;
          state_nxt   = WR_ISSUE;
        end
      end
      WR_ISSUE: if (!c_busy) state_nxt = WR_WAIT;
      WR_WAIT: begin
        // Request stays on the bus; the first non-busy cycle retires it.
        if (!c_busy) begin
          acc_done = 1'b1;
          tcnt_nxt = '0;
          if (idx != LastIdx) begin
            idx_nxt   = idx + 16'd1;
            addr_nxt  = c_address + 32'd4;
            din_nxt   = Seed ^ (c_address + 32'd4);
            state_nxt = WR_ISSUE;
          end else begin
            idx_nxt   = '0;
            addr_nxt  = BaseAddress;
            we_nxt    = 4'b0000;
            state_nxt = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: if (!c_busy) state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (c_data_out_ready && !c_busy) begin
          acc_done = 1'b1;
          tcnt_nxt = '0;
          mismatch = (c_data_out != (Seed ^ c_address));
          if (mismatch && error_count != 16'hFFFF) err_upd = error_count + 16'd1;
          if (mismatch && error_count == 16'd0) first_nxt = c_address;
          err_nxt = err_upd;
          if (idx != LastIdx) begin
            idx_nxt   = idx + 16'd1;
            addr_nxt  = c_address + 32'd4;
            state_nxt = RD_ISSUE;
          end else begin
            done_nxt  = 1'b1;
            pass_nxt  = (err_upd == 16'd0);
            en_nxt    = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Per-access watchdog; a completing access on the last allowed cycle wins.
    if ((state == WR_ISSUE || state == WR_WAIT || state == RD_ISSUE ||
         state == RD_WAIT) && !acc_done) begin
      if (tcnt >= TmoLast) begin
        done_nxt    = 1'b1;
        timeout_nxt = 1'b1;
        pass_nxt    = 1'b0;
        en_nxt      = 1'b0;
        we_nxt      = 4'b0000;
        state_nxt   = DONE;
      end else begin
        tcnt_nxt = tcnt + 32'd1;
      end
    end
  end

  // Registered datapath and cache-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx                 <= '0;
      tcnt                <= '0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      error_count         <= '0;
      first_error_address <= '0;
      c_enable            <= 1'b0;
      c_write_enable      <= 4'b0000;
      c_address           <= '0;
      c_data_in           <= '0;
    end else begin
      idx                 <= idx_nxt;
      tcnt                <= tcnt_nxt;
      done                <= done_nxt;
      pass                <= pass_nxt;
      timeout             <= timeout_nxt;
      error_count         <= err_nxt;
      first_error_address <= first_nxt;
      c_enable            <= en_nxt;
      c_write_enable      <= we_nxt;
      c_address           <= addr_nxt;
      c_data_in           <= din_nxt;
    end
  end

endmodule

// File: tb/tb_mem_tester.sv
// Directed bench for mem_tester: behavioural cache model, scenario table,
// memory-content table and hand sequences for timeout / reset / WordCount=1.
module tb_mem_tester;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 0: defaults ----------------
  logic        start;
  logic        done, pass, timeout;
  logic [15:0] error_count;
  logic [31:0] first_error_address;
  logic        c_enable;
  logic [3:0]  c_write_enable;
  logic [31:0] c_address, c_data_in, c_data_out;
  logic        c_data_out_ready, c_busy;

  mem_tester u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_error_address(first_error_address),
    .c_enable(c_enable), .c_write_enable(c_write_enable),
    .c_address(c_address), .c_data_in(c_data_in),
    .c_data_out(c_data_out), .c_data_out_ready(c_data_out_ready),
    .c_busy(c_busy)
  );

  // Cache model for DUT 0
  logic [31:0] mem [0:15];
  logic        rd_rdy = 1'b0;
  logic [31:0] rd_data = '0, rd_addr = '0;
  int          cyc = 0;
  logic        busy_hold = 1'b0, busy_toggle = 1'b0, clr_mem = 1'b0;
  logic        fault_en = 1'b0, fault_all = 1'b0;
  logic [31:0] fault_addr = '0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_rdy <= 1'b0;
    if (clr_mem) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'hDEAD_BEEF;
    end else if (c_enable && !c_busy) begin
      if (c_write_enable != 4'b0000) mem[c_address[5:2]] <= c_data_in;
      else begin
        rd_rdy  <= 1'b1;
        rd_data <= mem[c_address[5:2]];
        rd_addr <= c_address;
      end
    end
  end

  assign c_busy           = busy_hold | (busy_toggle & (cyc % 3 == 0));
  assign c_data_out_ready = rd_rdy;
  assign c_data_out       = (fault_all || (fault_en && rd_addr == fault_addr)) ? 32'h0 : rd_data;

  // ---------------- DUT 1: single word at 64 ----------------
  logic        start1;
  logic        done1, pass1, timeout1;
  logic [15:0] error_count1;
  logic [31:0] first_error_address1;
  logic        c_enable1;
  logic [3:0]  c_write_enable1;
  logic [31:0] c_address1, c_data_in1;
  logic [31:0] rd1_data = '0;
  logic        rd1_rdy = 1'b0;
  logic        c_busy1 = 1'b0;
  logic [31:0] m1_addr = '0, m1_data = '0;
  int          wr1_edges = 0;

  mem_tester #(.WordCount(1), .BaseAddress(32'd64)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .done(done1), .pass(pass1), .timeout(timeout1),
    .error_count(error_count1), .first_error_address(first_error_address1),
    .c_enable(c_enable1), .c_write_enable(c_write_enable1),
    .c_address(c_address1), .c_data_in(c_data_in1),
    .c_data_out(rd1_data), .c_data_out_ready(rd1_rdy),
    .c_busy(c_busy1)
  );

  always @(posedge clk) begin
    rd1_rdy <= 1'b0;
    if (c_enable1) begin
      if (c_write_enable1 != 4'b0000) begin
        m1_addr   <= c_address1;
        m1_data   <= c_data_in1;
        wr1_edges <= wr1_edges + 1;
      end else begin
        rd1_rdy  <= 1'b1;
        rd1_data <= (c_address1 == m1_addr) ? m1_data : 32'h0;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Clear model memory, pulse start, poke start again at edge 'poke', wait for done.
  task automatic run0(input int poke, output int n);
    @(negedge clk); clr_mem = 1'b1;
    @(negedge clk); clr_mem = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("restart_done_clr", done, 0);
    check("restart_err_clr", error_count, 0);
    check("restart_tmo_clr", timeout, 0);
    n = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    check("run_bound", done, 1);
  endtask

  typedef struct {
    string       name;
    logic        f_en;
    logic        f_all;
    logic [31:0] f_addr;
    logic        toggle;
    int          poke;
    int          exp_cyc;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
    logic        exp_pass;
  } scen_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } word_t;

  scen_t scen [6];
  word_t words [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    scen[0] = '{"clean",        0, 0, 32'd0,  0, -1, 64,  16'd0,  32'd0,  1};
    scen[1] = '{"fault12",      1, 0, 32'd12, 0, -1, 64,  16'd1,  32'd12, 0};
    scen[2] = '{"restart_poke", 0, 0, 32'd0,  0, 40, 64,  16'd0,  32'd0,  1};
    scen[3] = '{"fault60",      1, 0, 32'd60, 0, -1, 64,  16'd1,  32'd60, 0};
    scen[4] = '{"all_zero",     0, 1, 32'd0,  0, -1, 64,  16'd16, 32'd0,  0};
    scen[5] = '{"busy_toggle",  0, 0, 32'd0,  1, 5,  -1,  16'd0,  32'd0,  1};
    words[0] = '{32'd0,  32'h1234_5678};
    words[1] = '{32'd4,  32'h1234_567C};
    words[2] = '{32'd8,  32'h1234_5670};
    words[3] = '{32'd12, 32'h1234_5674};
    words[4] = '{32'd32, 32'h1234_5658};
    words[5] = '{32'd60, 32'h1234_5644};

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    #1;
    check("rst_c_enable", c_enable, 0);
    check("rst_c_we", c_write_enable, 0);
    check("rst_c_addr", c_address, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", error_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // WordCount=1 at base 64: one write, one read.
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin @(posedge clk); #1; n++; end
    check("wc1_done", done1, 1);
    check("wc1_cycles", n, 4);
    check("wc1_pass", pass1, 1);
    check("wc1_timeout", timeout1, 0);
    check("wc1_err", error_count1, 0);
    check("wc1_first", first_error_address1, 0);
    check("wc1_wr_addr", m1_addr, 32'd64);
    check("wc1_wr_data", m1_data, 32'h1234_5638);
    check("wc1_wr_edges", wr1_edges, 2);

    // Scenario table
    for (int s = 0; s < 6; s++) begin
      fault_en = scen[s].f_en; fault_all = scen[s].f_all;
      fault_addr = scen[s].f_addr; busy_toggle = scen[s].toggle;
      run0(scen[s].poke, n);
      if (scen[s].exp_cyc >= 0) check({scen[s].name, "_cycles"}, n, scen[s].exp_cyc);
      check({scen[s].name, "_done"}, done, 1);
      check({scen[s].name, "_pass"}, pass, scen[s].exp_pass);
      check({scen[s].name, "_timeout"}, timeout, 0);
      check({scen[s].name, "_err"}, error_count, scen[s].exp_err);
      check({scen[s].name, "_first"}, first_error_address, scen[s].exp_first);
      check({scen[s].name, "_c_enable"}, c_enable, 0);
    end
    fault_en = 1'b0; fault_all = 1'b0; busy_toggle = 1'b0;

    // Memory image written by the last run
    for (int w = 0; w < 6; w++)
      check($sformatf("mem_%0d", words[w].addr), mem[words[w].addr[5:2]], words[w].exp);

    // Timeout: cache never accepts
    busy_hold = 1'b1;
    run0(-1, n);
    check("tmo_cycles", n, 1023);
    check("tmo_flag", timeout, 1);
    check("tmo_pass", pass, 0);
    repeat (3) @(posedge clk); #1;
    check("tmo_done_hold", done, 1);
    check("tmo_c_enable", c_enable, 0);
    busy_hold = 1'b0;

    // Restart after timeout clears it and passes
    run0(-1, n);
    check("post_tmo_cycles", n, 64);
    check("post_tmo_pass", pass, 1);

    // Asynchronous reset mid-run, then no resumption
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    check("arst_c_enable", c_enable, 0);
    check("arst_c_we", c_write_enable, 0);
    check("arst_c_addr", c_address, 0);
    check("arst_c_din", c_data_in, 0);
    check("arst_done", done, 0);
    check("arst_timeout", timeout, 0);
    check("arst_first", first_error_address, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("arst_no_resume", c_enable, 0);
    check("arst_no_done", done, 0);
    run0(-1, n);
    check("arst_rerun_cycles", n, 64);
    check("arst_rerun_pass", pass, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
